// File: rtl/wb_pkg.sv
// Shared types and defaults for the writeback arbiter: default widths, the
// buffered write request record and the hard-wired zero register index.
package wb_pkg;
   localparam int WB_DATA_W = 32;
   localparam int WB_REG_W  = 5;

   localparam logic [WB_REG_W-1:0] R0 = '0;

   typedef struct packed {
      logic [WB_REG_W-1:0] idx;
      logic [WB_DATA_W-1:0] data;
   } wb_req_t;
endpackage

// File: rtl/wb_fifo.sv
// Small first-word-fall-through FIFO holding MDU results until a writeback slot opens.
// Pointers carry an extra wrap bit so full and empty are never ambiguous.
module wb_fifo
   import wb_pkg::*;
#(
   parameter int  DEPTH   = 4,
   parameter type entry_t = wb_req_t
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       push_i,
   input  entry_t                     din_i,
   input  logic                       pop_i,
   output entry_t                     dout_o,
   output logic                       full_o,
   output logic                       empty_o,
   output logic [$clog2(DEPTH+1)-1:0] count_o
);
   localparam int PTR_W = $clog2(DEPTH);
   localparam int CNT_W = $clog2(DEPTH+1);

   logic [PTR_W:0] wr_q, wr_d;
   logic [PTR_W:0] rd_q, rd_d;
   entry_t         mem_q [DEPTH];
   logic           do_push;
   logic           do_pop;

   assign empty_o = (wr_q == rd_q);
   assign full_o  = (wr_q[PTR_W] != rd_q[PTR_W]) &&
                    (wr_q[PTR_W-1:0] == rd_q[PTR_W-1:0]);
   assign count_o = CNT_W'(wr_q - rd_q);
   assign dout_o  = mem_q[rd_q[PTR_W-1:0]];

   // A push is refused when full even if the same cycle pops.
   assign do_push = push_i && !full_o;
   assign do_pop  = pop_i && !empty_o;

   always_comb begin
      wr_d = wr_q;
      rd_d = rd_q;
      if (do_push) wr_d = wr_q + 1'b1;
      if (do_pop)  rd_d = rd_q + 1'b1;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_q <= '0;
         rd_q <= '0;
      end else begin
         wr_q <= wr_d;
         rd_q <= rd_d;
      end
   end

   always_ff @(posedge clk) begin
      if (do_push) mem_q[wr_q[PTR_W-1:0]] <= din_i;
   end
endmodule

// File: rtl/wb_write_arbiter.sv
// Merges the pipeline WB result and buffered MDU results onto the single register file
// write port. Optional combinational forwarding of the landing write: define WB_FWD_EN.
module wb_write_arbiter
   import wb_pkg::*;
#(
   parameter int DATA_W     = WB_DATA_W,
   parameter int REG_W      = WB_REG_W,
   parameter int DEPTH      = 4,
   parameter int STARVE_MAX = 8
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       pipe_valid,
   input  logic [REG_W-1:0]           pipe_reg,
   input  logic [DATA_W-1:0]          pipe_data,
   input  logic                       mdu_valid,
   output logic                       mdu_ready,
   input  logic [REG_W-1:0]           mdu_reg,
   input  logic [DATA_W-1:0]          mdu_data,
   output logic [REG_W-1:0]           writereg,
   output logic [DATA_W-1:0]          writedata,
   output logic                       RegWrite,
   output logic [$clog2(DEPTH+1)-1:0] fifo_count,
   output logic                       stall_req
`ifdef WB_FWD_EN
   ,
   input  logic [REG_W-1:0]           readreg1,
   input  logic [REG_W-1:0]           readreg2,
   output logic                       fwd1_hit,
   output logic                       fwd2_hit,
   output logic [DATA_W-1:0]          fwd1_data,
   output logic [DATA_W-1:0]          fwd2_data
`endif
);
   localparam int SW = $clog2(STARVE_MAX+1);
   localparam logic [REG_W-1:0] ZERO_IDX = REG_W'(R0);

   typedef struct packed {
      logic [REG_W-1:0]  idx;
      logic [DATA_W-1:0] data;
   } entry_t;

   entry_t            push_req;
   entry_t            head;
   logic              fifo_full;
   logic              fifo_empty;
   logic              pipe_win;
   logic              pop;

   logic              regwrite_q, regwrite_d;
   logic [REG_W-1:0]  writereg_q, writereg_d;
   logic [DATA_W-1:0] writedata_q, writedata_d;
   logic [SW-1:0]     starve_q, starve_d;

   assign push_req  = '{idx: mdu_reg, data: mdu_data};
   assign mdu_ready = !fifo_full && !rst;

   wb_fifo #(
      .DEPTH   (DEPTH),
      .entry_t (entry_t)
   ) u_fifo (
      .clk     (clk),
      .rst     (rst),
      .push_i  (mdu_valid && mdu_ready),
      .din_i   (push_req),
      .pop_i   (pop),
      .dout_o  (head),
      .full_o  (fifo_full),
      .empty_o (fifo_empty),
      .count_o (fifo_count)
   );

   // A pipe write to r0 is a free slot, so the FIFO may drain through it.
   assign pipe_win = pipe_valid && (pipe_reg != ZERO_IDX);
   assign pop      = !pipe_win && !fifo_empty;

   always_comb begin
      regwrite_d  = 1'b0;
      writereg_d  = writereg_q;
      writedata_d = writedata_q;
      starve_d    = starve_q;
      if (pipe_win) begin
         regwrite_d  = 1'b1;
         writereg_d  = pipe_reg;
         writedata_d = pipe_data;
      end else if (pop) begin
         regwrite_d  = (head.idx != ZERO_IDX);
         writereg_d  = head.idx;
         writedata_d = head.data;
      end
      if (fifo_empty || pop)
         starve_d = '0;
      else if (starve_q != SW'(STARVE_MAX))
         starve_d = starve_q + 1'b1;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         regwrite_q  <= 1'b0;
         writereg_q  <= '0;
         writedata_q <= '0;
         starve_q    <= '0;
      end else begin
         regwrite_q  <= regwrite_d;
         writereg_q  <= writereg_d;
         writedata_q <= writedata_d;
         starve_q    <= starve_d;
      end
   end

   assign RegWrite  = regwrite_q;
   assign writereg  = writereg_q;
   assign writedata = writedata_q;
   assign stall_req = (starve_q == SW'(STARVE_MAX));

`ifdef WB_FWD_EN
   assign fwd1_hit  = regwrite_q && (writereg_q == readreg1) && (readreg1 != ZERO_IDX);
   assign fwd2_hit  = regwrite_q && (writereg_q == readreg2) && (readreg2 != ZERO_IDX);
   assign fwd1_data = fwd1_hit ? writedata_q : '0;
   assign fwd2_data = fwd2_hit ? writedata_q : '0;
`endif
endmodule
